change_dispenser_ctrl: RTL
==========================

CHANGE_DISPENSER_CTRL -- requirements
Module: change_dispenser_ctrl

Interface
REQ-001 Parameter STOCK_INIT, default 8: per-denomination coin count loaded at reset.
REQ-002 Parameter STOCK_W, default 8: width of each stock counter; maximum count is 2^STOCK_W-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 i_start  input  1  one-cycle request to return i_amount; honoured only in IDLE.
REQ-006 i_amount  input  16  return amount in KRW, sampled with i_start.
REQ-007 i_coin_ready  input  1  dispenser can accept a coin this cycle.
REQ-008 i_refill  input  3  per-cycle refill of one coin each: [0]=100, [1]=500, [2]=1000.
REQ-009 o_return_coin  output  3  registered one-hot coin pulse: [0]=100, [1]=500, [2]=1000.
REQ-010 o_busy  output  1  high in DISPENSE.
REQ-011 o_done  output  1  one-cycle pulse when a return finishes, whether complete or short.
REQ-012 o_short  output  1  last return ended with unpaid residual; held until the next accepted i_start.
REQ-013 o_remaining  output  16  unpaid residual in KRW.
REQ-014 o_stock_100, o_stock_500, o_stock_1000  output  STOCK_W each  current coin counts.

Function
REQ-015 FSM states are IDLE and DISPENSE; IDLE -> DISPENSE on i_start, DISPENSE -> IDLE on termination.
REQ-016 On the accepting edge: o_remaining <= i_amount, o_short <= 0, o_return_coin <= 0.
REQ-017 Coin selection per DISPENSE edge with i_coin_ready=1: greedy choice of the largest coin with value <= o_remaining and stock > 0.
REQ-018 On that edge: o_return_coin <= selected one-hot, o_remaining -= coin value, selected stock decrements by 1.
REQ-019 o_return_coin SHALL be 3'b000 on every edge that does not dispense; each coin is high exactly one cycle.
REQ-020 With i_coin_ready=0 in DISPENSE, no state changes except refill.
REQ-021 Termination is evaluated before selection on each DISPENSE edge, regardless of i_coin_ready.
REQ-022 Termination, o_remaining==0: -> IDLE, o_done pulse, o_short=0.
REQ-023 Termination, o_remaining>0 with no eligible coin (includes residual < 100): -> IDLE, o_done pulse, o_short=1, o_remaining holds the residual.
REQ-024 Latency: the first coin is visible after the 2nd edge following i_start with i_coin_ready held high.
REQ-025 Throughput: one coin per cycle; o_done is asserted one edge after the last coin.
REQ-026 i_amount=0 on start: DISPENSE for one edge, then o_done pulse with o_short=0.
REQ-027 i_start in DISPENSE is ignored; i_amount is not re-sampled.
REQ-028 Refill: each set i_refill bit adds 1 on that edge, saturating at 2^STOCK_W-1; refill works in any state.
REQ-029 Simultaneous refill and dispense of the same denomination leaves that stock unchanged; at saturation the net change is -1.
REQ-030 Arithmetic is unsigned 16-bit; o_remaining never underflows because selection guarantees value <= remaining.

Reset
REQ-031 A reset_n=0 edge forces, from any state, including mid-return: IDLE; o_return_coin=0, o_busy=0, o_done=0, o_short=0, o_remaining=0; all stocks = STOCK_INIT.
REQ-032 A return interrupted by reset is abandoned, with no further coins and no o_done.
REQ-033 Reset has priority over i_start, i_refill and dispensing on the same edge.

Configuration
REQ-034 Macro CHANGE_STOCK_EN defined: stock tracking, refill and stock-limited selection apply as in REQ-017 to REQ-029.
REQ-035 Macro CHANGE_STOCK_EN undefined: stock is unlimited; i_refill is ignored; o_stock_* tie to 0; o_short is set only for a residual < 100.

Verification
REQ-036 Macro defined, stocks 8/8/8: start 4800, ready high -> coins 1000 x4, 500, 100 x3 on consecutive cycles; then o_done, o_remaining=0, stocks 5/7/4.
REQ-037 Macro defined, 1000-stock 0, start 2000 -> 500 x4, o_short=0; 500-stock drops by 4.
REQ-038 Macro defined, stocks 100:1, 500:0, 1000:0, start 700 -> single 100 coin, then o_done, o_short=1, o_remaining=600.
REQ-039 Start 1500 with i_coin_ready toggling 1,0,1,0 -> coins only on ready cycles (1000, then 500); o_done after the 500.
REQ-040 Start 3000, reset_n=0 after the 1st coin -> no further coins, no o_done, all outputs at reset values, stocks = STOCK_INIT.
REQ-041 Start 250 -> 100, 100, then o_done with o_short=1 and o_remaining=50; with the macro undefined, same result.

Source files
------------

// File: rtl/change_dispenser_ctrl.sv
// Coin-change return controller: greedy 1000/500/100 KRW dispensing, one coin per ready cycle.
// Define CHANGE_STOCK_EN to enable per-denomination stock tracking, refill and stock-limited selection.
module change_dispenser_ctrl #(
    parameter int STOCK_INIT = 8,
    parameter int STOCK_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic [15:0]        i_amount,
    input  logic               i_coin_ready,
    input  logic [2:0]         i_refill,
    output logic [2:0]         o_return_coin,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_short,
    output logic [15:0]        o_remaining,
    output logic [STOCK_W-1:0] o_stock_100,
    output logic [STOCK_W-1:0] o_stock_500,
    output logic [STOCK_W-1:0] o_stock_1000
);

    typedef enum logic {
        IDLE     = 1'b0,
        DISPENSE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  coin_q, coin_d;
    logic        done_q, done_d;
    logic        short_q, short_d;
    logic [15:0] rem_q, rem_d;

    logic [2:0]  avail;
    logic [2:0]  eligible;
    logic [2:0]  sel;
    logic [15:0] sel_val;

`ifdef CHANGE_STOCK_EN
    localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);

    logic [STOCK_W-1:0] stock_q [3];
    logic [STOCK_W-1:0] stock_d [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            avail[i] = (stock_q[i] != '0);
        end
    end

    // Refill saturates first, so refill plus dispense at full stock nets -1.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stock_d[i] = stock_q[i];
            if (i_refill[i] && (stock_q[i] != STOCK_MAX)) begin
                stock_d[i] = stock_q[i] + STOCK_W'(1);
            end
            if (coin_d[i]) begin
                stock_d[i] = stock_d[i] - STOCK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                stock_q[i] <= STOCK_RST;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign o_stock_100  = stock_q[0];
    assign o_stock_500  = stock_q[1];
    assign o_stock_1000 = stock_q[2];
`else
    localparam int unused_stock_init = STOCK_INIT;
    logic unused_refill;

    assign unused_refill = ^i_refill;
    assign avail         = 3'b111;
    assign o_stock_100   = '0;
    assign o_stock_500   = '0;
    assign o_stock_1000  = '0;
`endif

    // Greedy pick: largest coin that fits the residual and is in stock.
    always_comb begin
        eligible[2] = (rem_q >= 16'd1000) && avail[2];
        eligible[1] = (rem_q >= 16'd500)  && avail[1];
        eligible[0] = (rem_q >= 16'd100)  && avail[0];
        sel     = 3'b000;
        sel_val = 16'd0;
        if (eligible[2]) begin
            sel     = 3'b100;
            sel_val = 16'd1000;
        end else if (eligible[1]) begin
            sel     = 3'b010;
            sel_val = 16'd500;
        end else if (eligible[0]) begin
            sel     = 3'b001;
            sel_val = 16'd100;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        coin_d  = 3'b000;
        done_d  = 1'b0;
        short_d = short_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = DISPENSE;
                    rem_d   = i_amount;
                    short_d = 1'b0;
                end
            end
            DISPENSE: begin
                // Termination takes precedence over dispensing and ignores i_coin_ready.
                if (rem_q == 16'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    short_d = 1'b0;
                end else if (sel == 3'b000) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    short_d = 1'b1;
                end else if (i_coin_ready) begin
                    coin_d = sel;
                    rem_d  = rem_q - sel_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            coin_q  <= 3'b000;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            rem_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            coin_q  <= coin_d;
            done_q  <= done_d;
            short_q <= short_d;
            rem_q   <= rem_d;
        end
    end

    assign o_return_coin = coin_q;
    assign o_busy        = (state_q == DISPENSE);
    assign o_done        = done_q;
    assign o_short       = short_q;
    assign o_remaining   = rem_q;

endmodule
